cmult_shared_sched: RTL

- Round-robin scheduler that shares one time-multiplexed complex multiplier among NREQ requesters.
- Each operation uses a single signed real multiplier over three cycles, with the 3-multiply decomposition:
  - k1 = a_re*(b_re+b_im)
  - k2 = b_im*(a_re+a_im)
  - k3 = b_re*(a_im-a_re)
  - res_re = k1-k2, res_im = k1+k3
- Sits between several DSP channels and the shared multiplier resource. Returns a tagged result per operation.

---
 rtl/cmult_shared_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cmult_shared_sched.sv
// rtl/cmult_shared_sched.sv - round-robin scheduler sharing one 3-cycle complex multiplier
// Optional CMULT_FIXED_PRIO_EN: fixed priority (lowest req index wins), no rr pointer.
module cmult_shared_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         a_re_bus,
    input  logic [NREQ*W-1:0]         a_im_bus,
    input  logic [NREQ*W-1:0]         b_re_bus,
    input  logic [NREQ*W-1:0]         b_im_bus,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      res_valid,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic signed [2*W-1:0]     res_re,
    output logic signed [2*W-1:0]     res_im
);
    localparam int IDW = $clog2(NREQ);
    localparam int KW  = 2*W + 2;

    typedef enum logic [1:0] {IDLE, K1, K2, K3} state_t;
    state_t state;

    logic signed [W-1:0]  a_re_q, a_im_q, b_re_q, b_im_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       winner;
    logic signed [KW-1:0] k1_q, k2_q;
    logic signed [W:0]    sum;
    logic signed [W-1:0]  mop;
    logic signed [KW-1:0] mul_a, mul_b, prod;

`ifdef CMULT_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[i]) winner = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] ptr;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int  idx;
        logic found;
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end
`endif

    // One signed multiplier: (W+1)-bit sum/difference times a W-bit operand.
    always_comb begin
        sum = '0;
        mop = '0;
        case (state)
            K1: begin
                sum = {b_re_q[W-1], b_re_q} + {b_im_q[W-1], b_im_q};
                mop = a_re_q;
            end
            K2: begin
                sum = {a_re_q[W-1], a_re_q} + {a_im_q[W-1], a_im_q};
                mop = b_im_q;
            end
            K3: begin
                sum = {a_im_q[W-1], a_im_q} - {a_re_q[W-1], a_re_q};
                mop = b_re_q;
            end
            default: ;
        endcase
    end

    assign mul_a = KW'(sum);
    assign mul_b = KW'(mop);
    assign prod  = mul_a * mul_b;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_re    <= '0;
            res_im    <= '0;
            a_re_q    <= '0;
            a_im_q    <= '0;
            b_re_q    <= '0;
            b_im_q    <= '0;
            id_q      <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
`ifndef CMULT_FIXED_PRIO_EN
            ptr       <= IDW'(NREQ-1);
`endif
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        a_re_q <= a_re_bus[winner*W +: W];
                        a_im_q <= a_im_bus[winner*W +: W];
                        b_re_q <= b_re_bus[winner*W +: W];
                        b_im_q <= b_im_bus[winner*W +: W];
                        id_q   <= winner;
                        gnt    <= NREQ'(1) << winner;
`ifndef CMULT_FIXED_PRIO_EN
                        ptr    <= winner;
`endif
                        state  <= K1;
                    end
                end
                K1: begin
                    k1_q  <= prod;
                    state <= K2;
                end
                K2: begin
                    k2_q  <= prod;
                    state <= K3;
                end
                K3: begin
                    res_re    <= (2*W)'(k1_q - k2_q);
                    res_im    <= (2*W)'(k1_q + prod);
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
